uart_rx_block_packer: RTL and testbench

// - Downstream of uart_rx: consumes its 8-bit AXI-Stream byte output.
// - Packs BLOCK_BYTES consecutive bytes into one wide word (default 128 bit) and presents it
//   on an AXI-Stream master port to the AES core.
// - An inter-byte idle timeout discards stale partial blocks, or pads and emits them (see CONFIGURATION).

---
 rtl/uart_rx_block_packer_if.sv | 29 ++
 rtl/uart_rx_block_packer.sv | 131 +++++++++++++
 tb/tb_uart_rx_block_packer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_block_packer_if.sv
//------------------------------------------------------------------------------
// Module : uart_rx_block_packer_byte_if / uart_rx_block_packer_blk_if
// Brief  : AXI-Stream byte input and wide block output bundles for the packer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_block_packer_byte_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;

   modport master (output tdata, output tvalid, input  tready);
   modport slave  (input  tdata, input  tvalid, output tready);
endinterface

interface uart_rx_block_packer_blk_if #(
   parameter int BLOCK_BYTES = 16
);
   logic [8*BLOCK_BYTES-1:0] tdata;
   logic                     tvalid;
   logic                     tready;
   logic                     tuser;

   modport master (output tdata, output tvalid, output tuser, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tuser, output tready);
endinterface

`default_nettype wire

// File: rtl/uart_rx_block_packer.sv
//------------------------------------------------------------------------------
// Module : uart_rx_block_packer
// Brief  : Packs BLOCK_BYTES UART bytes MSB-first into one wide AXI-Stream word,
//          with an inter-byte idle timeout. Optional macro
//          UART_RX_BLOCK_PACKER_PAD_EN emits padded partial blocks on timeout.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_block_packer #(
   parameter int BLOCK_BYTES = 16,
   parameter int TIMEOUT_W   = 16
) (
   input  wire logic                               clk,
   input  wire logic                               rst,
   input  wire logic                               en,
   uart_rx_block_packer_byte_if.slave              s_axis,
   uart_rx_block_packer_blk_if.master              m_axis,
   input  wire logic [TIMEOUT_W-1:0]               timeout_cycles,
   output logic      [$clog2(BLOCK_BYTES+1)-1:0]   byte_count,
   output logic                                    timeout_event,
   output logic                                    busy
);

   localparam int CNT_W = $clog2(BLOCK_BYTES+1);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_OUT  = 1'b1
   } state_t;

   state_t                   r_state, w_state_nxt;
   logic [8*BLOCK_BYTES-1:0] r_block, w_block_nxt;
   logic [CNT_W-1:0]         r_count, w_count_nxt;
   logic [TIMEOUT_W-1:0]     r_idle,  w_idle_nxt;
   logic                     r_tuser, w_tuser_nxt;
   logic                     r_timeout_event, w_timeout_event_nxt;

   logic                     w_accept;
   logic                     w_idle_tick;
   logic                     w_threshold;
   logic [TIMEOUT_W:0]       w_idle_plus1;

   assign w_accept     = (r_state == S_FILL) && en && s_axis.tvalid;
   assign w_idle_tick  = (r_state == S_FILL) && en && (r_count != '0) && !w_accept
                         && (timeout_cycles != '0);
   assign w_idle_plus1 = {1'b0, r_idle} + {{TIMEOUT_W{1'b0}}, 1'b1};
   // >= rather than == so a threshold lowered mid-count still fires
   assign w_threshold  = w_idle_plus1 >= {1'b0, timeout_cycles};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_FILL;
         r_block         <= '0;
         r_count         <= '0;
         r_idle          <= '0;
         r_tuser         <= 1'b0;
         r_timeout_event <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_block         <= w_block_nxt;
         r_count         <= w_count_nxt;
         r_idle          <= w_idle_nxt;
         r_tuser         <= w_tuser_nxt;
         r_timeout_event <= w_timeout_event_nxt;
      end
   end

   always_comb begin
      w_state_nxt         = r_state;
      w_block_nxt         = r_block;
      w_count_nxt         = r_count;
      w_idle_nxt          = r_idle;
      w_tuser_nxt         = r_tuser;
      w_timeout_event_nxt = 1'b0;

      case (r_state)
         S_FILL: begin
            if (w_accept) begin
               for (int i = 0; i < BLOCK_BYTES; i++) begin
                  if (r_count == CNT_W'(i)) begin
                     w_block_nxt[8*(BLOCK_BYTES-1-i) +: 8] = s_axis.tdata;
                  end
               end
               w_count_nxt = r_count + CNT_W'(1);
               w_idle_nxt  = '0;
               if (r_count == CNT_W'(BLOCK_BYTES-1)) begin
                  w_state_nxt = S_OUT;
               end
            end else if (w_idle_tick) begin
               if (w_threshold) begin
                  w_idle_nxt          = '0;
                  w_timeout_event_nxt = 1'b1;
`ifdef UART_RX_BLOCK_PACKER_PAD_EN
                  // unfilled slots are already zero; count is kept as true length
                  w_state_nxt = S_OUT;
                  w_tuser_nxt = 1'b1;
`else
                  w_count_nxt = '0;
                  w_block_nxt = '0;
`endif
               end else begin
                  w_idle_nxt = w_idle_plus1[TIMEOUT_W-1:0];
               end
            end
         end
         S_OUT: begin
            if (m_axis.tready) begin
               w_state_nxt = S_FILL;
               w_count_nxt = '0;
               w_block_nxt = '0;
               w_tuser_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_FILL;
         end
      endcase
   end

   assign s_axis.tready = (r_state == S_FILL) && en;
   assign m_axis.tdata  = r_block;
   assign m_axis.tvalid = (r_state == S_OUT);
   assign m_axis.tuser  = r_tuser;
   assign byte_count    = r_count;
   assign timeout_event = r_timeout_event;
   assign busy          = (r_count != '0) || (r_state == S_OUT);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_block_packer.sv
//------------------------------------------------------------------------------
// Module : tb_uart_rx_block_packer
// Brief  : Scoreboard bench for uart_rx_block_packer (default 16-byte blocks).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_block_packer;

   localparam int BB = 16;

   typedef struct {
      logic [8*BB-1:0] data;
      logic            user;
   } blk_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [15:0] timeout_cycles = '0;
   logic [4:0]  byte_count;
   logic        timeout_event;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int blocks_seen = 0;

   blk_t       exp_q[$];
   logic [7:0] mdl[$];

   uart_rx_block_packer_byte_if                     s_if ();
   uart_rx_block_packer_blk_if #(.BLOCK_BYTES(BB))  m_if ();

   uart_rx_block_packer #(.BLOCK_BYTES(BB), .TIMEOUT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .s_axis         (s_if),
      .m_axis         (m_if),
      .timeout_cycles (timeout_cycles),
      .byte_count     (byte_count),
      .timeout_event  (timeout_event),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8*BB-1:0] pack_model();
      logic [8*BB-1:0] w;
      w = '0;
      for (int i = 0; i < mdl.size(); i++) w[8*(BB-1-i) +: 8] = mdl[i];
      return w;
   endfunction

   task automatic model_accept(input logic [7:0] b);
      blk_t e;
      mdl.push_back(b);
      if (mdl.size() == BB) begin
         e.data = pack_model();
         e.user = 1'b0;
         exp_q.push_back(e);
         mdl.delete();
      end
   endtask

   task automatic model_timeout();
`ifdef UART_RX_BLOCK_PACKER_PAD_EN
      blk_t e;
      e.data = pack_model();
      e.user = 1'b1;
      exp_q.push_back(e);
`endif
      mdl.delete();
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      logic acc;
      acc = 1'b0;
      s_if.tdata  = b;
      s_if.tvalid = 1'b1;
      for (int k = 0; k < 500 && !acc; k++) begin
         @(negedge clk);
         acc = s_if.tready;
         @(posedge clk);
         #1;
      end
      s_if.tvalid = 1'b0;
      if (!acc) check_val("send_accept_bound", 0, 1);
      else      model_accept(b);
   endtask

   task automatic wait_timeout(input int bound, output int first, output int pulses,
                               output logic [4:0] bc_at, output logic tv_at);
      first  = -1;
      pulses = 0;
      bc_at  = '1;
      tv_at  = 1'bx;
      for (int k = 1; k <= bound; k++) begin
         @(posedge clk);
         #1;
         if (timeout_event) begin
            pulses++;
            if (first < 0) begin
               first = k;
               bc_at = byte_count;
               tv_at = m_if.tvalid;
               model_timeout();
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst && m_if.tvalid && m_if.tready) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_block", 1, 0);
         end else begin
            blk_t e;
            e = exp_q.pop_front();
            check_val("blk_tdata", m_if.tdata, e.data);
            check_val("blk_tuser", m_if.tuser, e.user);
            blocks_seen++;
         end
      end
   end

   initial begin
      int          first, pulses, evs, exp_blocks;
      logic [4:0]  bc_at;
      logic        tv_at;

      s_if.tdata   = '0;
      s_if.tvalid  = 1'b0;
      m_if.tready  = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_tvalid",  m_if.tvalid, 0);
      check_val("rst_tdata",   m_if.tdata, 0);
      check_val("rst_tuser",   m_if.tuser, 0);
      check_val("rst_count",   byte_count, 0);
      check_val("rst_busy",    busy, 0);
      check_val("rst_tevent",  timeout_event, 0);
      check_val("rst_s_tready", s_if.tready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b1;
      @(negedge clk);
      check_val("idle_s_tready", s_if.tready, 1);
      @(posedge clk);
      #1;

      // full block, consumer ready
      m_if.tready = 1'b1;
      for (int i = 0; i < BB; i++) send_byte(8'(i));
      check_val("full_tvalid_lat", m_if.tvalid, 1);
      check_val("full_count", byte_count, 16);
      check_val("full_busy", busy, 1);
      @(posedge clk);
      #1;
      check_val("full_tvalid_clr", m_if.tvalid, 0);
      check_val("full_count_clr", byte_count, 0);

      // backpressure
      m_if.tready = 1'b0;
      for (int i = 0; i < BB; i++) send_byte(8'h20 + 8'(i));
      s_if.tdata  = 8'h55;
      s_if.tvalid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_val("bp_s_tready", s_if.tready, 0);
         check_val("bp_tvalid", m_if.tvalid, 1);
         check_val("bp_tdata", m_if.tdata, 128'h202122232425262728292A2B2C2D2E2F);
      end
      @(posedge clk);
      #1;
      m_if.tready = 1'b1;
      send_byte(8'h55);
      for (int i = 1; i < BB; i++) send_byte(8'h55 + 8'(i));
      @(posedge clk);
      #1;

      // timeout after 100 idle cycles
      timeout_cycles = 16'd100;
      send_byte(8'hAA);
      send_byte(8'hBB);
      wait_timeout(150, first, pulses, bc_at, tv_at);
      check_val("to_first_cycle", first, 100);
      check_val("to_pulses", pulses, 1);
`ifdef UART_RX_BLOCK_PACKER_PAD_EN
      check_val("to_count", bc_at, 2);
      check_val("to_tvalid", tv_at, 1);
`else
      check_val("to_count", bc_at, 0);
      check_val("to_tvalid", tv_at, 0);
`endif
      @(posedge clk);
      #1;

      // timeout disabled
      timeout_cycles = '0;
      for (int i = 1; i <= 3; i++) send_byte(8'(i));
      evs = 0;
      for (int c = 0; c < 70000; c++) begin
         @(posedge clk);
         #1;
         if (timeout_event) evs++;
      end
      check_val("nto_events", evs, 0);
      check_val("nto_count", byte_count, 3);

      // asynchronous reset mid-block
      for (int i = 4; i <= 7; i++) send_byte(8'(i));
      check_val("rb_count_pre", byte_count, 7);
      rst = 1'b1;
      #1;
      check_val("rb_count_async", byte_count, 0);
      check_val("rb_busy_async", busy, 0);
      mdl.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < BB; i++) send_byte(8'h10 + 8'(i));
      @(posedge clk);
      #1;

      // enable gating freezes accept and idle counter
      timeout_cycles = 16'd20;
      for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
      en          = 1'b0;
      s_if.tdata  = 8'h99;
      s_if.tvalid = 1'b1;
      evs = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (timeout_event) evs++;
         if (s_if.tready) evs++;
      end
      check_val("en_events_or_ready", evs, 0);
      check_val("en_count_held", byte_count, 4);
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
      en          = 1'b1;
      wait_timeout(40, first, pulses, bc_at, tv_at);
      check_val("en_to_first", first, 20);
      check_val("en_to_pulses", pulses, 1);

      // drain
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
      repeat (2) @(posedge clk);
`ifdef UART_RX_BLOCK_PACKER_PAD_EN
      exp_blocks = 6;
`else
      exp_blocks = 4;
`endif
      check_val("queue_empty", exp_q.size(), 0);
      check_val("blocks_seen", blocks_seen, exp_blocks);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
